// File: rtl/regfile_pkg.sv
// Shared widths, register-file constants and the write-back entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

   localparam int AW       = 5;
   localparam int DW       = 32;
   localparam int NUM_REGS = 32;

   localparam logic [AW-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_wb_buffer_if.sv
// Bundles the write-back, read-request and Register_file port signals of the buffer.
// Latency: n/a (wiring only).
// Backpressure: wb_ready/rd_ready are driven by the buffer (slave side).
interface regfile_wb_buffer_if;
   import regfile_pkg::*;

   logic          wb_valid;
   logic          wb_ready;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;

   logic          rd_req;
   logic          rd_ready;
   logic [AW-1:0] rd_addr1;
   logic [AW-1:0] rd_addr2;
   logic          rd_valid;
   logic [DW-1:0] rd_data1;
   logic [DW-1:0] rd_data2;

   logic          rf_re;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [AW-1:0] rf_raddr1;
   logic [AW-1:0] rf_raddr2;
   logic [DW-1:0] rf_rdata1;
   logic [DW-1:0] rf_rdata2;

   // Buffer side.
   modport slave (
      input  wb_valid, wb_addr, wb_data, rd_req, rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
      output wb_ready, rd_ready, rd_valid, rd_data1, rd_data2,
             rf_re, rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2
   );

   // Pipeline and Register_file side.
   modport master (
      output wb_valid, wb_addr, wb_data, rd_req, rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
      input  wb_ready, rd_ready, rd_valid, rd_data1, rd_data2,
             rf_re, rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2
   );

endinterface

// File: rtl/wb_fifo.sv
// Write-back queue with a two-port youngest-match address lookup over the live entries.
// Latency: push/pop take effect at the clock edge; head and lookup are combinational.
// Backpressure: caller must not push when full (unless popping) nor pop when empty.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  wb_entry_t     push_entry,
   input  logic          pop,
   output wb_entry_t     head,
   output logic          full,
   output logic          empty,
   input  logic [AW-1:0] lk_addr1,
   input  logic [AW-1:0] lk_addr2,
   output logic          lk_hit1,
   output logic [DW-1:0] lk_data1,
   output logic          lk_hit2,
   output logic [DW-1:0] lk_data2
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t       mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   // Entry storage needs no reset: only slots below count are ever looked at.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   // Pointers wrap naturally on power-of-2 depth; count tracks occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Scan oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      lk_hit1  = 1'b0;
      lk_data1 = '0;
      lk_hit2  = 1'b0;
      lk_data2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count) begin
            if (mem[rd_ptr + PW'(i)].addr == lk_addr1) begin
               lk_hit1  = 1'b1;
               lk_data1 = mem[rd_ptr + PW'(i)].data;
            end
            if (mem[rd_ptr + PW'(i)].addr == lk_addr2) begin
               lk_hit2  = 1'b1;
               lk_data2 = mem[rd_ptr + PW'(i)].data;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_wb_buffer.sv
// Queues write-backs, drains them into Register_file on read-free cycles, forwards pending data to reads.
// Latency: read data valid one cycle after the read fires; a queued write drains on the next read-free cycle.
// Backpressure: wb_ready and rd_ready both drop while the queue is full, forcing a drain cycle.
module regfile_wb_buffer
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   regfile_wb_buffer_if.slave bus
);

   logic          full;
   logic          empty;
   logic          wb_acc;
   logic          rd_fire;
   logic          push;
   logic          pop;
   wb_entry_t     head;
   wb_entry_t     push_entry;

   logic          lk_hit1;
   logic          lk_hit2;
   logic [DW-1:0] lk_data1;
   logic [DW-1:0] lk_data2;
   logic          byp1;
   logic          byp2;
   logic          hit1_n;
   logic          hit2_n;
   logic [DW-1:0] data1_n;
   logic [DW-1:0] data2_n;

   logic          rd_valid_q;
   logic          fwd_hit1;
   logic          fwd_hit2;
   logic [DW-1:0] fwd_data1;
   logic [DW-1:0] fwd_data2;

   // The Register_file port is shared: reads win, and a full queue holds off reads so it can drain.
   assign wb_acc   = bus.wb_valid && !full;
   assign rd_fire  = bus.rd_req && !full;
   assign push     = wb_acc && (bus.wb_addr != ZERO_REG);
   assign pop      = !rd_fire && !empty;

   assign push_entry = '{addr: bus.wb_addr, data: bus.wb_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (full),
      .empty      (empty),
      .lk_addr1   (bus.rd_addr1),
      .lk_addr2   (bus.rd_addr2),
      .lk_hit1    (lk_hit1),
      .lk_data1   (lk_data1),
      .lk_hit2    (lk_hit2),
      .lk_data2   (lk_data2)
   );

   assign bus.wb_ready  = !full;
   assign bus.rd_ready  = !full;
   assign bus.rf_re     = rd_fire;
   assign bus.rf_raddr1 = bus.rd_addr1;
   assign bus.rf_raddr2 = bus.rd_addr2;
   assign bus.rf_we     = pop;
   assign bus.rf_waddr  = head.addr;
   assign bus.rf_wdata  = head.data;

   // A write accepted this cycle is younger than anything queued, so it takes priority.
   assign byp1    = wb_acc && (bus.wb_addr == bus.rd_addr1);
   assign byp2    = wb_acc && (bus.wb_addr == bus.rd_addr2);
   assign hit1_n  = (bus.rd_addr1 != ZERO_REG) && (byp1 || lk_hit1);
   assign hit2_n  = (bus.rd_addr2 != ZERO_REG) && (byp2 || lk_hit2);
   assign data1_n = byp1 ? bus.wb_data : lk_data1;
   assign data2_n = byp2 ? bus.wb_data : lk_data2;

   // Capture the forwarding decision alongside the Register_file read it pairs with.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         fwd_hit1   <= 1'b0;
         fwd_hit2   <= 1'b0;
         fwd_data1  <= '0;
         fwd_data2  <= '0;
      end else begin
         rd_valid_q <= rd_fire;
         if (rd_fire) begin
            fwd_hit1  <= hit1_n;
            fwd_hit2  <= hit2_n;
            fwd_data1 <= data1_n;
            fwd_data2 <= data2_n;
         end
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data1 = !rd_valid_q ? '0 : (fwd_hit1 ? fwd_data1 : bus.rf_rdata1);
   assign bus.rd_data2 = !rd_valid_q ? '0 : (fwd_hit2 ? fwd_data2 : bus.rf_rdata2);

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Directed and random stimulus against an architectural register model plus a pending-write queue model.
// Latency: reads are expected back one cycle after they fire.
// Backpressure: readiness is predicted from the model queue occupancy.
module tb_regfile_wb_buffer;
   import regfile_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset_n;

   regfile_wb_buffer_if bus ();

   regfile_wb_buffer #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Register_file stand-in: one access per cycle, read has priority, registered read data.
   logic [DW-1:0] rf_mem [NUM_REGS];
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) rf_mem[i] <= '0;
         bus.rf_rdata1 <= '0;
         bus.rf_rdata2 <= '0;
      end else if (bus.rf_re) begin
         bus.rf_rdata1 <= rf_mem[bus.rf_raddr1];
         bus.rf_rdata2 <= rf_mem[bus.rf_raddr2];
      end else if (bus.rf_we && bus.rf_waddr != ZERO_REG) begin
         rf_mem[bus.rf_waddr] <= bus.rf_wdata;
      end
   end

   // Reference model: architectural values (updated on acceptance) and writes not yet drained.
   logic [DW-1:0] arch [NUM_REGS];
   wb_entry_t     mq [$];
   logic          exp_pend;
   logic [DW-1:0] exp_d1;
   logic [DW-1:0] exp_d2;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_REGS; i++) arch[i] = '0;
      mq.delete();
      exp_pend = 1'b0;
      exp_d1   = '0;
      exp_d2   = '0;
   endtask

   // One clock cycle: check last cycle's read result, drive inputs, check scheduling, advance model.
   task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rq, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      logic      rdy;
      logic      fire;
      logic      acc;
      wb_entry_t e;
      @(negedge clk);
      check("rd_valid", 32'(bus.rd_valid), 32'(exp_pend));
      if (exp_pend) begin
         check("rd_data1", bus.rd_data1, exp_d1);
         check("rd_data2", bus.rd_data2, exp_d2);
      end
      bus.wb_valid = wv;
      bus.wb_addr  = wa;
      bus.wb_data  = wd;
      bus.rd_req   = rq;
      bus.rd_addr1 = a1;
      bus.rd_addr2 = a2;
      #1;
      rdy  = (mq.size() < DEPTH);
      fire = rq && rdy;
      acc  = wv && rdy;
      check("wb_ready", 32'(bus.wb_ready), 32'(rdy));
      check("rd_ready", 32'(bus.rd_ready), 32'(rdy));
      check("rf_re", 32'(bus.rf_re), 32'(fire));
      if (fire) begin
         check("rf_we_during_read", 32'(bus.rf_we), 32'd0);
         check("rf_raddr1", 32'(bus.rf_raddr1), 32'(a1));
         check("rf_raddr2", 32'(bus.rf_raddr2), 32'(a2));
      end else begin
         check("rf_we", 32'(bus.rf_we), 32'(mq.size() > 0));
         if (mq.size() > 0) begin
            check("rf_waddr", 32'(bus.rf_waddr), 32'(mq[0].addr));
            check("rf_wdata", bus.rf_wdata, mq[0].data);
         end
      end
      if (!fire && mq.size() > 0) void'(mq.pop_front());
      if (acc && wa != ZERO_REG) begin
         arch[wa] = wd;
         e.addr = wa;
         e.data = wd;
         mq.push_back(e);
      end
      exp_pend = fire;
      if (fire) begin
         exp_d1 = arch[a1];
         exp_d2 = arch[a2];
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   initial begin
      reset_n      = 1'b0;
      bus.wb_valid = 1'b0;
      bus.wb_addr  = '0;
      bus.wb_data  = '0;
      bus.rd_req   = 1'b0;
      bus.rd_addr1 = '0;
      bus.rd_addr2 = '0;
      model_clear();
      #12;
      check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("reset_rd_data1", bus.rd_data1, 32'd0);
      check("reset_wb_ready", 32'(bus.wb_ready), 32'd1);
      check("reset_rf_we", 32'(bus.rf_we), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      idle(2);

      // Idle write drains next cycle, then reads back.
      step(1'b1, 5'd3, 32'hAAAA, 1'b0, '0, '0);
      idle(2);
      step(1'b0, '0, '0, 1'b1, 5'd3, 5'd0);
      idle(1);

      // Read starvation: continuous reads while four writes fill the queue.
      for (int i = 0; i < 4; i++) step(1'b1, AW'(10 + i), 32'h1000 + i, 1'b1, 5'd3, AW'(10 + i));
      step(1'b0, '0, '0, 1'b1, 5'd11, 5'd12);
      step(1'b0, '0, '0, 1'b1, 5'd10, 5'd13);
      idle(5);

      // Forward from queue: youngest of two pending writes to r5 wins.
      step(1'b1, 5'd5, 32'd1, 1'b1, 5'd1, 5'd2);
      step(1'b1, 5'd5, 32'd2, 1'b1, 5'd1, 5'd2);
      step(1'b0, '0, '0, 1'b1, 5'd5, 5'd5);
      idle(4);

      // Same-cycle bypass on port 1, Register_file value on port 2.
      step(1'b1, 5'd8, 32'h88, 1'b0, '0, '0);
      idle(2);
      step(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd8);
      idle(3);

      // Writes to $zero are dropped; r0 reads as 0.
      step(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0);
      idle(1);
      step(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0);
      idle(1);

      // Reset mid-operation: three queued entries and a read in flight.
      step(1'b1, 5'd20, 32'h20, 1'b1, 5'd1, 5'd2);
      step(1'b1, 5'd21, 32'h21, 1'b1, 5'd1, 5'd2);
      step(1'b1, 5'd22, 32'h22, 1'b1, 5'd20, 5'd21);
      @(posedge clk);
      #1;
      check("inflight_rd_valid", 32'(bus.rd_valid), 32'd1);
      bus.wb_valid = 1'b0;
      bus.rd_req   = 1'b0;
      reset_n      = 1'b0;
      #1;
      check("midreset_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("midreset_wb_ready", 32'(bus.wb_ready), 32'd1);
      check("midreset_rd_ready", 32'(bus.rd_ready), 32'd1);
      check("midreset_rf_we", 32'(bus.rf_we), 32'd0);
      model_clear();
      @(negedge clk);
      reset_n = 1'b1;
      idle(1);
      step(1'b0, '0, '0, 1'b1, 5'd20, 5'd22);
      idle(1);

      // Random traffic on a small address range to force conflicts.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 99) < 55, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      end
      idle(8);
      for (int r = 0; r < 8; r++) step(1'b0, '0, '0, 1'b1, AW'(r), AW'(7 - r));
      idle(2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
